// File: rtl/ens_vote_argmax.sv
// Ensemble vote combiner: sums NUM_ENS per-class score vectors, then scans the
// class sums one per cycle for the argmax, with ties going to the lowest index.
module ens_vote_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 2,
    parameter int NUM_ENS     = 4,
    localparam int SUM_W      = SCORE_W + $clog2(NUM_ENS),
    localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLS_W-1:0]               out_class,
    output logic [SUM_W-1:0]               out_score
);
    localparam int CNT_W = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;
    localparam int IDX_W = $clog2(NUM_CLASSES + 1);

    typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sums [NUM_CLASSES];
    logic [CNT_W-1:0] member_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [SUM_W-1:0] best;
    logic [CLS_W-1:0] best_idx;
    logic [SUM_W-1:0] scan_sum;
    logic             last_beat;
    logic             scan_done;

    assign last_beat = (member_cnt == CNT_W'(NUM_ENS - 1));
    // scan_idx runs one past the last class so the final compare gets its own cycle
    assign scan_done = (scan_idx == IDX_W'(NUM_CLASSES));
    assign scan_sum  = scan_done ? '0 : sums[scan_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_done) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign out_class = out_valid ? best_idx : '0;
    assign out_score = out_valid ? best : '0;

    // NOTE: the accumulator array is reset explicitly; a discarded partial frame must not leak into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
            member_cnt <= '0;
            scan_idx   <= '0;
            best       <= '0;
            best_idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    scan_idx <= '0;
                    if (in_valid) begin
                        for (int c = 0; c < NUM_CLASSES; c++)
                            sums[c] <= sums[c] + SUM_W'(in_scores[c*SCORE_W +: SCORE_W]);
                        member_cnt <= last_beat ? '0 : member_cnt + CNT_W'(1);
                    end
                end
                SCAN: begin
                    if (!scan_done) begin
                        // strict greater-than keeps the earliest index on ties
                        if (scan_idx == '0 || scan_sum > best) begin
                            best     <= scan_sum;
                            best_idx <= CLS_W'(scan_idx);
                        end
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
                        best     <= '0;
                        best_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Scoreboard bench for ens_vote_argmax: frames are modelled as plain per-class
// sums plus a max search; a negedge monitor checks every output handshake.
module tb_ens_vote_argmax;
    localparam int NC   = 10;
    localparam int SW   = 2;
    localparam int NE   = 4;
    localparam int SUMW = SW + $clog2(NE);
    localparam int CW   = $clog2(NC);
    localparam int VW   = NC * SW;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        int cls;
        int score;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    vec_t            in_scores;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_class;
    logic [SUMW-1:0] out_score;

    logic dir_ready;
    logic rnd_ready = 1'b1;
    logic rand_ready;
    assign out_ready = rand_ready ? rnd_ready : dir_ready;

    ens_vote_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_ENS(NE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scores (in_scores),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   last_accept_edge = 0;
    int   last_hs_edge     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int c, input int v);
        vec_t t = '0;
        t[c*SW +: SW] = v[SW-1:0];
        return t;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input vec_t v, output int edge_no);
        int n = 0;
        in_valid  = 1'b1;
        in_scores = v;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            edge_no = -1;
        end else begin
            edge_no = cyc + 1;
        end
        last_accept_edge = edge_no;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_scores = vec_t'($urandom);
    endtask

    task automatic send_frame(input vec_t beats[NE], input int gap1, input bit push,
                              output int first_edge);
        int sums[NC];
        int best = -1;
        int idx  = NC;
        int e_no;
        foreach (sums[c]) sums[c] = 0;
        for (int e = 0; e < NE; e++)
            for (int c = 0; c < NC; c++)
                sums[c] += int'(beats[e][c*SW +: SW]);
        for (int c = 0; c < NC; c++) if (sums[c] > best) best = sums[c];
        for (int c = NC - 1; c >= 0; c--) if (sums[c] == best) idx = c;
        if (push) sb.push_back('{cls: idx, score: best});
        first_edge = 0;
        for (int e = 0; e < NE; e++) begin
            send_beat(beats[e], e_no);
            if (e == 0) begin
                first_edge = e_no;
                repeat (gap1) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sync();
    endtask

    // Output monitor
    logic            prev_valid = 1'b0;
    logic [CW-1:0]   held_cls;
    logic [SUMW-1:0] held_sc;
    exp_t            got;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_in_out", 32'(in_ready), 0);
                if (!prev_valid) begin
                    check("latency", cyc - last_accept_edge, NC + 1);
                end else begin
                    check("hold_class", 32'(out_class), 32'(held_cls));
                    check("hold_score", 32'(out_score), 32'(held_sc));
                end
                held_cls = out_class;
                held_sc  = out_score;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        got = sb.pop_front();
                        check("class", 32'(out_class), got.cls);
                        check("score", 32'(out_score), got.score);
                    end
                    last_hs_edge = cyc + 1;
                end
            end else begin
                check("idle_class", 32'(out_class), 0);
                check("idle_score", 32'(out_score), 0);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        vec_t beats[NE];
        int   f1;
        int   f2;
        int   hs_snap;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_scores  = '0;
        dir_ready  = 1'b1;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_class", 32'(out_class), 0);
        check("rst_out_score", 32'(out_score), 0);
        sync();

        // Single hot class
        for (int e = 0; e < NE; e++) beats[e] = mk(3, 3);
        send_frame(beats, 0, 1, f1);
        wait_drain();

        // Tie between classes 2 and 7 at 6
        beats[0] = mk(2, 2) | mk(7, 3) | mk(5, 1) | mk(0, 1);
        beats[1] = mk(2, 2) | mk(7, 3) | mk(5, 1);
        beats[2] = mk(2, 1) | mk(5, 1) | mk(9, 3);
        beats[3] = mk(2, 1) | mk(5, 2) | mk(9, 2);
        send_frame(beats, 0, 1, f1);
        wait_drain();

        // Input gap and output stall with stray in_valid pulses
        dir_ready = 1'b0;
        for (int e = 0; e < NE; e++) beats[e] = vec_t'($urandom);
        send_frame(beats, 3, 1, f1);
        wait_valid();
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_scores = vec_t'($urandom);
        end
        in_valid  = 1'b0;
        dir_ready = 1'b1;
        wait_drain();

        // Reset during the fourth SCAN cycle discards the frame
        for (int e = 0; e < NE; e++) beats[e] = vec_t'($urandom) | mk(4, 3);
        send_frame(beats, 0, 0, f1);
        repeat (3) sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("midscan_in_ready", 32'(in_ready), 1);
        check("midscan_out_valid", 32'(out_valid), 0);
        sync();
        for (int e = 0; e < NE; e++) beats[e] = mk(9, 1);
        send_frame(beats, 0, 1, f1);
        wait_drain();

        // Back-to-back frames with in_valid held high
        for (int e = 0; e < NE; e++) beats[e] = vec_t'($urandom);
        send_frame(beats, 0, 1, f1);
        for (int e = 0; e < NE; e++) beats[e] = vec_t'($urandom);
        send_frame(beats, 0, 1, f2);
        hs_snap = last_hs_edge;
        check("b2b_first_accept", f2, hs_snap + 1);
        wait_drain();

        // Random frames with random gaps and random output backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int e = 0; e < NE; e++) beats[e] = vec_t'($urandom);
            send_frame(beats, $urandom_range(0, 2), 1, f1);
        end
        wait_drain();
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
